core_ctrl: RTL and testbench
============================

Name: core_ctrl

Overview:
- Instruction sequencer for the systolic-array `core`.
- Each `start` runs one complete convolution tile. Per kernel position (kij) it loads weights, streams activations, executes, and drains the output FIFO into psum memory. After the last kij it runs the accumulate pass.
- Sits between the top-level testbench/host and `core`. Drives the `core.inst[33:0]` bus every cycle and observes `core.ofifo_valid`.

Parameters:
- row, 16, array rows (activation vector width in words)
- col, 16, array columns (number of weight vectors per kij)
- addr_w, 11, SRAM address width for xmem and pmem
- cnt_w, 8, width of the length and kij counters

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a tile when idle
- n_kij  input  cnt_w  number of kernel positions; sampled on accepted start; 0 is treated as 1
- len_nij  input  cnt_w  activations per kij; sampled on accepted start; 0 is treated as 1
- w_base  input  addr_w  xmem base address of the weights
- x_base  input  addr_w  xmem base address of the activations
- ofifo_valid  input  1  from core; output FIFO holds a row
- inst  output  34  registered instruction word to core
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse in the cycle after the final accumulate read

Behaviour:
- inst fields:
  - [33] acc
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
  - Chip enables and write enables are active-low.
- IDLE word = 34'h1_800C_0000: CEN/WEN of both SRAMs high, all else 0.
- All outputs are registered. Reset (any state) forces IDLE state, inst = IDLE word, busy = 0, done = 0, and all counters = 0 on the next edge.
- start is accepted only in IDLE and is ignored while busy. Config inputs are latched on acceptance.
- FSM states: IDLE -> WL0 -> WLD -> XL0 -> EXE -> DRAIN -> (kij+1 < n_kij ? WL0 : ACC) -> DONE -> IDLE.
- WL0, col+1 cycles:
  - Cycles 0..col-1 read xmem: CEN_xmem = 0, WEN_xmem = 1, A_xmem = w_base + kij*col + i.
  - l0_wr = 1 in cycles 1..col (one-cycle SRAM latency).
- WLD, col+row cycles:
  - Cycles 0..col-1: l0_rd = 1, load = 1.
  - Remaining row cycles: all-idle settle time.
- XL0, len_nij+1 cycles:
  - Cycles 0..len_nij-1 read xmem: A_xmem = x_base + t.
  - l0_wr = 1 in cycles 1..len_nij.
- EXE, len_nij+row+col cycles:
  - Cycles 0..len_nij-1: l0_rd = 1, execute = 1.
  - Remaining cycles: idle flush.
- DRAIN:
  - In any cycle where ofifo_valid = 1 and k < len_nij: ofifo_rd = 1, CEN_pmem = 0, WEN_pmem = 0, A_pmem = kij*len_nij + k. Then k increments.
  - Cycles with ofifo_valid = 0 issue the IDLE word (stall). There is no timeout.
  - Exit when k reaches len_nij.
  - ofifo_valid is ignored in all other states.
- ACC, n_kij*len_nij cycles:
  - Iteration order: o outer over 0..len_nij-1, kij inner over 0..n_kij-1.
  - Each cycle: acc = 1, CEN_pmem = 0, WEN_pmem = 1, A_pmem = kij*len_nij + o.
- DONE: one cycle; inst = IDLE word, done = 1, busy = 0 from the next cycle. A start in the DONE cycle is ignored.
- Address arithmetic is unsigned and truncated to addr_w bits; wrap-around is not flagged.
- Fields not named for a state are at their IDLE-word value.

Test Plan:
- Reset mid-EXE (row = col = 4, n_kij = 2, len_nij = 6) -> next cycle inst = 34'h1_800C_0000, busy = 0; a subsequent start runs a full tile from kij = 0.
- n_kij = 1, len_nij = 4, row = col = 4, w_base = 0x10, x_base = 0x40, ofifo_valid held 1 ->
  - WL0 addresses 0x10..0x13, l0_wr lagging by one cycle.
  - load high for 4 cycles.
  - XL0 addresses 0x40..0x43.
  - execute high for 4 cycles.
  - pmem writes at 0..3, then acc reads 0..3.
  - done pulses once.
- n_kij = 3, len_nij = 2 -> WL0 bases 0x10, 0x14, 0x18; DRAIN writes 0..5; ACC A_pmem sequence 0, 2, 4, 1, 3, 5.
- DRAIN with ofifo_valid toggling 1, 0, 0, 1, 1 for len_nij = 3 -> exactly 3 ofifo_rd/pmem-write cycles, aligned to the valid-high cycles; stall cycles carry the IDLE word.
- start pulsed during busy and in the DONE cycle -> ignored; only one done per accepted start.
- len_nij = 0 and n_kij = 0 -> behaves as 1/1; A_pmem values near 2^addr_w wrap without error.

Source files
------------

// File: rtl/core_ctrl.sv
// Instruction sequencer for the systolic-array core: one convolution tile per start.
// Each kij runs weight load, activation stream, execute and drain; an accumulate pass follows.
module core_ctrl #(
    parameter int row    = 16,
    parameter int col    = 16,
    parameter int addr_w = 11,
    parameter int cnt_w  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [cnt_w-1:0]  n_kij,
    input  logic [cnt_w-1:0]  len_nij,
    input  logic [addr_w-1:0] w_base,
    input  logic [addr_w-1:0] x_base,
    input  logic              ofifo_valid,
    output logic [33:0]       inst,
    output logic              busy,
    output logic              done
);

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
    localparam int PH_W = $clog2((1 << cnt_w) + row + col + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WL0, S_WLD, S_XL0, S_EXE, S_DRAIN, S_ACC, S_DONE
    } state_t;

    state_t            state;
    logic [PH_W-1:0]   ph;
    logic [PH_W-1:0]   ph_nx;
    logic [cnt_w-1:0]  kij, k, o;
    logic [cnt_w-1:0]  kij_nx, o_nx;
    logic [cnt_w-1:0]  n_r, len_r;
    logic [addr_w-1:0] w_base_r, x_base_r;

    assign ph_nx  = ph + 1'b1;
    assign kij_nx = kij + 1'b1;
    assign o_nx   = o + 1'b1;

    function automatic logic [addr_w-1:0] addr_of(logic [31:0] base, logic [31:0] a,
                                                  logic [31:0] b, logic [31:0] off);
        logic [31:0] s;
        s = base + a * b + off;
        return s[addr_w-1:0];
    endfunction

    // xmem read in cycles 0..n-1; the L0 write trails by one cycle for SRAM latency
    function automatic logic [33:0] xmem_rd(logic [addr_w-1:0] a, logic [PH_W-1:0] i,
                                            logic [PH_W-1:0] n);
        logic [33:0] w;
        w = IDLE_WORD;
        if (i < n) begin
            w[19]          = 1'b0;
            w[7 +: addr_w] = a;
        end
        if (i != '0) w[2] = 1'b1;
        return w;
    endfunction

    function automatic logic [33:0] stream(logic [PH_W-1:0] i, logic [PH_W-1:0] n, logic exe);
        logic [33:0] w;
        w = IDLE_WORD;
        if (i < n) begin
            w[3] = 1'b1;
            if (exe) w[1] = 1'b1;
            else     w[0] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [33:0] pmem(logic acc, logic [addr_w-1:0] a);
        logic [33:0] w;
        w               = IDLE_WORD;
        w[32]           = 1'b0;
        w[20 +: addr_w] = a;
        if (acc) begin
            w[33] = 1'b1;
        end else begin
            w[31] = 1'b0;
            w[6]  = 1'b1;
        end
        return w;
    endfunction

    // inst always carries the word for the cycle the FSM is currently in, so each
    // transition loads the first word of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ph    <= '0;
            kij   <= '0;
            k     <= '0;
            o     <= '0;
            inst  <= IDLE_WORD;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_r      <= (n_kij == '0) ? cnt_w'(1) : n_kij;
                        len_r    <= (len_nij == '0) ? cnt_w'(1) : len_nij;
                        w_base_r <= w_base;
                        x_base_r <= x_base;
                        kij      <= '0;
                        ph       <= '0;
                        busy     <= 1'b1;
                        state    <= S_WL0;
                        inst     <= xmem_rd(w_base, '0, PH_W'(col));
                    end
                end
                S_WL0: begin
                    if (ph == PH_W'(col)) begin
                        ph    <= '0;
                        state <= S_WLD;
                        inst  <= stream('0, PH_W'(col), 1'b0);
                    end else begin
                        ph   <= ph_nx;
                        inst <= xmem_rd(addr_of(32'(w_base_r), 32'(kij), 32'(col), 32'(ph_nx)),
                                        ph_nx, PH_W'(col));
                    end
                end
                S_WLD: begin
                    if (ph == PH_W'(col + row - 1)) begin
                        ph    <= '0;
                        state <= S_XL0;
                        inst  <= xmem_rd(x_base_r, '0, PH_W'(len_r));
                    end else begin
                        ph   <= ph_nx;
                        inst <= stream(ph_nx, PH_W'(col), 1'b0);
                    end
                end
                S_XL0: begin
                    if (ph == PH_W'(len_r)) begin
                        ph    <= '0;
                        state <= S_EXE;
                        inst  <= stream('0, PH_W'(len_r), 1'b1);
                    end else begin
                        ph   <= ph_nx;
                        inst <= xmem_rd(addr_of(32'(x_base_r), 32'd0, 32'd0, 32'(ph_nx)),
                                        ph_nx, PH_W'(len_r));
                    end
                end
                S_EXE: begin
                    if (ph == PH_W'(len_r) + PH_W'(row + col - 1)) begin
                        ph    <= '0;
                        k     <= '0;
                        state <= S_DRAIN;
                        inst  <= IDLE_WORD;
                    end else begin
                        ph   <= ph_nx;
                        inst <= stream(ph_nx, PH_W'(len_r), 1'b1);
                    end
                end
                // ofifo_valid seen in a cycle is answered by the pmem write in the next one
                S_DRAIN: begin
                    if (k == len_r) begin
                        if (kij_nx < n_r) begin
                            kij   <= kij_nx;
                            ph    <= '0;
                            state <= S_WL0;
                            inst  <= xmem_rd(addr_of(32'(w_base_r), 32'(kij_nx), 32'(col), 32'd0),
                                             '0, PH_W'(col));
                        end else begin
                            kij   <= '0;
                            o     <= '0;
                            state <= S_ACC;
                            inst  <= pmem(1'b1, '0);
                        end
                    end else if (ofifo_valid) begin
                        k    <= k + 1'b1;
                        inst <= pmem(1'b0, addr_of(32'd0, 32'(kij), 32'(len_r), 32'(k)));
                    end else begin
                        inst <= IDLE_WORD;
                    end
                end
                S_ACC: begin
                    if (kij_nx < n_r) begin
                        kij  <= kij_nx;
                        inst <= pmem(1'b1, addr_of(32'd0, 32'(kij_nx), 32'(len_r), 32'(o)));
                    end else if (o_nx < len_r) begin
                        kij  <= '0;
                        o    <= o_nx;
                        inst <= pmem(1'b1, addr_of(32'd0, 32'd0, 32'(len_r), 32'(o_nx)));
                    end else begin
                        state <= S_DONE;
                        inst  <= IDLE_WORD;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    inst  <= IDLE_WORD;
                end
                default: begin
                    state <= S_IDLE;
                    inst  <= IDLE_WORD;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: a tile-level trace model queues the expected
// per-cycle {inst, busy, done}; a monitor pops and compares every cycle.
module tb_core_ctrl;

    localparam int R = 4, C = 4, AW = 11, CW = 8, VP = 16384;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic          clk = 1'b0;
    logic          reset, start, ofifo_valid;
    logic [CW-1:0] n_kij, len_nij;
    logic [AW-1:0] w_base, x_base;
    logic [33:0]   inst;
    logic          busy, done;

    typedef struct {
        int          cyc;
        logic [33:0] inst;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_seen = 0;
    int   done_exp = 0;
    bit   vpat[VP];

    core_ctrl #(.row(R), .col(C), .addr_w(AW), .cnt_w(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .n_kij(n_kij), .len_nij(len_nij),
        .w_base(w_base), .x_base(x_base), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc = cyc + 1; end

    function automatic logic [33:0] mk_word(bit acc, bit cenp, bit wenp, int ap,
                                            bit cenx, bit wenx, int ax, logic [6:0] ctl);
        logic [10:0] a_p, a_x;
        a_p = ap[10:0];
        a_x = ax[10:0];
        return {acc, cenp, wenp, a_p, cenx, wenx, a_x, ctl};
    endfunction

    function automatic bit vat(int r);
        return (r < VP) ? vpat[r] : 1'b1;
    endfunction

    task automatic push(input int c, input logic [33:0] w, input logic b, input logic d);
        exp_t e;
        e.cyc = c; e.inst = w; e.busy = b; e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // mode: 0 random valid, 1 valid held high, 2 scripted 1,0,0,1,1 from first DRAIN cycle
    task automatic run_tile(input int n_in, input int len_in, input int wb, input int xb,
                            input int mode, input int rst_at, input bit start_in_done);
        int n, L, c0, T, k, de;
        logic [33:0] tw[$];
        n = (n_in == 0) ? 1 : n_in;
        L = (len_in == 0) ? 1 : len_in;
        for (int r = 0; r < VP; r++) vpat[r] = (mode == 1) ? 1'b1 : 1'($urandom);
        if (mode == 2) begin
            de = (C + 1) + (C + R) + (L + 1) + (L + R + C);
            vpat[de + 1] = 1'b1; vpat[de + 2] = 1'b0; vpat[de + 3] = 1'b0;
            vpat[de + 4] = 1'b1; vpat[de + 5] = 1'b1;
        end
        for (int kj = 0; kj < n; kj++) begin
            for (int i = 0; i <= C; i++)
                tw.push_back(mk_word(0, 1, 1, 0, i >= C, 1, (i < C) ? (wb + kj * C + i) : 0,
                                     (i > 0) ? 7'b0000100 : 7'b0000000));
            for (int i = 0; i < C + R; i++)
                tw.push_back((i < C) ? mk_word(0, 1, 1, 0, 1, 1, 0, 7'b0001001) : IDLE_W);
            for (int t = 0; t <= L; t++)
                tw.push_back(mk_word(0, 1, 1, 0, t >= L, 1, (t < L) ? (xb + t) : 0,
                                     (t > 0) ? 7'b0000100 : 7'b0000000));
            for (int t = 0; t < L + R + C; t++)
                tw.push_back((t < L) ? mk_word(0, 1, 1, 0, 1, 1, 0, 7'b0001010) : IDLE_W);
            tw.push_back(IDLE_W);
            k = 0;
            while (k < L) begin
                if (vat(tw.size())) begin
                    tw.push_back(mk_word(0, 0, 0, kj * L + k, 1, 1, 0, 7'b1000000));
                    k++;
                end else begin
                    tw.push_back(IDLE_W);
                end
            end
        end
        for (int o = 0; o < L; o++)
            for (int kj = 0; kj < n; kj++)
                tw.push_back(mk_word(1, 0, 1, kj * L + o, 1, 1, 0, 7'b0000000));
        tw.push_back(IDLE_W);
        T = tw.size();

        step;
        c0 = cyc;
        push(c0, IDLE_W, 1'b0, 1'b0);
        start = 1'b1;
        n_kij = CW'(n_in); len_nij = CW'(len_in);
        w_base = AW'(wb);  x_base = AW'(xb);
        ofifo_valid = 1'($urandom);
        for (int j = 0; j < T; j++)
            if (rst_at == 0 || j < rst_at) push(c0 + 1 + j, tw[j], 1'b1, j == T - 1);
        if (rst_at == 0) done_exp++;

        for (int r = 1; r <= T + 1; r++) begin
            step;
            if (rst_at > 0 && r == rst_at + 1) begin
                reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
                push(c0 + r, IDLE_W, 1'b0, 1'b0);
                break;
            end
            if (r == T + 1) begin
                start = 1'b0;
                push(c0 + r, IDLE_W, 1'b0, 1'b0);
                break;
            end
            start = (r == T) ? start_in_done : ($urandom_range(5, 0) == 0);
            n_kij = CW'($urandom); len_nij = CW'($urandom);
            w_base = AW'($urandom); x_base = AW'($urandom);
            ofifo_valid = vat(r);
            reset = (r == rst_at);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                vectors++;
                if (e.cyc < cyc) begin
                    miscompares++;
                    $display("FAIL stale@%0d: expectation for cycle %0d not compared", cyc, e.cyc);
                end else if (inst !== e.inst || busy !== e.busy || done !== e.done) begin
                    miscompares++;
                    $display("FAIL out@%0d: got inst=%h busy=%b done=%b, want inst=%h busy=%b done=%b",
                             cyc, inst, busy, done, e.inst, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
        n_kij = '0; len_nij = '0; w_base = '0; x_base = '0;
        for (int c = 1; c <= 3; c++) push(c, IDLE_W, 1'b0, 1'b0);
        step; step; step;
        reset = 1'b0;

        run_tile(2, 6, 'h10, 'h40, 1, 24, 1'b0);
        run_tile(2, 6, 'h10, 'h40, 1, 0, 1'b0);
        run_tile(1, 4, 'h10, 'h40, 1, 0, 1'b0);
        run_tile(3, 2, 'h10, 'h40, 1, 0, 1'b1);
        run_tile(1, 3, 'h10, 'h40, 2, 0, 1'b0);
        run_tile(0, 0, 'h20, 'h30, 0, 0, 1'b1);
        run_tile(40, 60, 'h7F8, 'h7FE, 1, 0, 1'b0);
        for (int t = 0; t < 8; t++)
            run_tile($urandom_range(4, 0), $urandom_range(7, 0), $urandom_range(2047, 0),
                     $urandom_range(2047, 0), 0, 0, 1'($urandom));

        step; step; step;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
        end
        vectors++;
        if (done_seen != done_exp) begin
            miscompares++;
            $display("FAIL done_count: got %0d done pulses, want %0d", done_seen, done_exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
